// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: major opcodes and immediate format codes.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct3 values of OP-IMM that encode a shift amount instead of an immediate
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: combinational decode plus an optional one-cycle
// registered copy for pipelined datapaths. Only XLEN = 32 is supported.
module imm_gen
  import rv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      imm_type,
  output logic            imm_valid,
  output logic [XLEN-1:0] imm_q,
  output logic [2:0]      imm_type_q
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  imm_type_e  typ;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Classify the opcode into an immediate format
  always_comb begin
    typ = IMM_NONE;
    unique case (opcode)
      OPC_OPIMM: begin
        if (funct3 == F3_SLLI || funct3 == F3_SRLI_SRAI) typ = IMM_SHAMT;
        else                                             typ = IMM_I;
      end
      OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: typ = IMM_I;
      OPC_STORE:                                 typ = IMM_S;
      OPC_BRANCH:                                typ = IMM_B;
      OPC_LUI, OPC_AUIPC:                        typ = IMM_U;
      OPC_JAL:                                   typ = IMM_J;
      default:                                   typ = IMM_NONE;
    endcase
  end

  // Assemble the immediate for the selected format; sign always from instr[31]
  always_comb begin
    imm_out = '0;
    unique case (typ)
      IMM_I:     imm_out = {{20{instr[31]}}, instr[31:20]};
      IMM_SHAMT: imm_out = {27'd0, instr[24:20]};
      IMM_S:     imm_out = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm_out = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
      IMM_U:     imm_out = {instr[31:12], 12'd0};
      IMM_J:     imm_out = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
      default:   imm_out = '0;
    endcase
  end

  assign imm_type  = typ;
  assign imm_valid = (typ != IMM_NONE);

  if (REG_OUT) begin : g_reg
    // Pipeline copy of the immediate; reset wins over capture
    always_ff @(posedge clk) begin
      if (rst) begin
        imm_q      <= '0;
        imm_type_q <= '0;
      end else begin
        imm_q      <= imm_out;
        imm_type_q <= imm_type;
      end
    end
  end else begin : g_noreg
    assign imm_q      = '0;
    assign imm_type_q = '0;
  end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed vectors with literal expectations,
// plus a field-arithmetic reference model checked on every falling edge.
module tb_imm_gen;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] imm_out;
  logic [2:0]  imm_type;
  logic        imm_valid;
  logic [31:0] imm_q;
  logic [2:0]  imm_type_q;

  int n_checks = 0;
  int n_fail   = 0;

  imm_gen #(.XLEN(32), .REG_OUT(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .imm_out    (imm_out),
    .imm_type   (imm_type),
    .imm_valid  (imm_valid),
    .imm_q      (imm_q),
    .imm_type_q (imm_type_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sign-extend the low 'bits' bits of v using plain arithmetic
  function automatic logic [31:0] sx(input longint v, input int bits);
    longint m;
    m = v & ((64'sd1 <<< bits) - 1);
    if (m >= (64'sd1 <<< (bits - 1))) m = m - (64'sd1 <<< bits);
    return m[31:0];
  endfunction

  // Reference: {type[2:0], imm[31:0]} from the instruction-format rules
  function automatic logic [34:0] model(input logic [31:0] w);
    longint u;
    int     op, f3;
    logic [31:0] imm;
    logic [2:0]  t;
    u   = longint'(w);
    op  = int'(u & 127);
    f3  = int'((u >> 12) & 7);
    imm = 32'd0;
    t   = 3'd0;
    if (op == 7'h13 && (f3 == 1 || f3 == 5)) begin
      t = 3'd6; imm = 32'((u >> 20) & 31);
    end else if (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h0F || op == 7'h73) begin
      t = 3'd1; imm = sx(u >> 20, 12);
    end else if (op == 7'h23) begin
      t = 3'd2; imm = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
    end else if (op == 7'h63) begin
      t = 3'd3;
      imm = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
               (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
    end else if (op == 7'h37 || op == 7'h17) begin
      t = 3'd4; imm = 32'(u & 64'hFFFFF000);
    end else if (op == 7'h6F) begin
      t = 3'd5;
      imm = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
               (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
    end
    return {t, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (instr=%h)", name, act, exp, instr);
    end
  endtask

  // Expected registered state, updated with the instr/rst seen at each rising edge
  logic [31:0] exp_q;
  logic [2:0]  exp_tq;
  logic        q_known = 1'b0;

  // Track what the output register must hold after each rising edge
  always @(posedge clk) begin
    logic [34:0] m;
    m = model(instr);
    if (rst) begin
      exp_q = '0; exp_tq = '0; q_known = 1'b1;
    end else begin
      exp_q = m[31:0]; exp_tq = m[34:32];
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    logic [34:0] m;
    m = model(instr);
    check("model_imm",   imm_out, m[31:0]);
    check("model_type",  {29'd0, imm_type}, {29'd0, m[34:32]});
    check("model_valid", {31'd0, imm_valid}, {31'd0, (m[34:32] != 3'd0)});
    if (q_known) begin
      check("model_imm_q",  imm_q, exp_q);
      check("model_type_q", {29'd0, imm_type_q}, {29'd0, exp_tq});
    end
  end

  typedef struct {
    logic [31:0] w;
    logic [31:0] imm;
    logic [2:0]  t;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Apply one instruction after a rising edge and check the literal expectation
  task automatic apply(input vec_t v);
    logic [34:0] m;
    @(posedge clk); #1;
    instr = v.w;
    #1;
    check({v.name, "_imm"},   imm_out, v.imm);
    check({v.name, "_type"},  {29'd0, imm_type}, {29'd0, v.t});
    check({v.name, "_valid"}, {31'd0, imm_valid}, {31'd0, (v.t != 3'd0)});
    m = model(v.w);
    check({v.name, "_model"}, m[31:0], v.imm);
  endtask

  initial begin
    logic [6:0] ops[12];
    rst   = 1'b1;
    instr = 32'd0;

    // Reset held for two edges clears the register
    repeat (2) @(posedge clk);
    #1;
    check("rst_imm_q",  imm_q, 32'd0);
    check("rst_type_q", {29'd0, imm_type_q}, 32'd0);

    rst = 1'b0;
    vecs.push_back('{32'hFFF10093, 32'hFFFFFFFF, 3'd1, "i_neg"});
    vecs.push_back('{32'h7FF00013, 32'h000007FF, 3'd1, "i_max"});
    vecs.push_back('{32'h00112423, 32'h00000008, 3'd2, "s"});
    vecs.push_back('{32'h00208063, 32'h00000000, 3'd3, "b_zero"});
    vecs.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, "b_neg"});
    vecs.push_back('{32'h000120B7, 32'h00012000, 3'd4, "u"});
    vecs.push_back('{32'h004000EF, 32'h00000004, 3'd5, "j"});
    vecs.push_back('{32'h00000000, 32'h00000000, 3'd0, "zero"});
    vecs.push_back('{32'h40305093, 32'h00000003, 3'd6, "srai"});
    vecs.push_back('{32'h01F09093, 32'h0000001F, 3'd6, "slli"});
    vecs.push_back('{32'h002081B3, 32'h00000000, 3'd0, "rtype"});
    vecs.push_back('{32'h80000017, 32'h80000000, 3'd4, "auipc"});
    vecs.push_back('{32'h800000EF, 32'hFFF00000, 3'd5, "j_neg"});
    vecs.push_back('{32'h80000023, 32'hFFFFF800, 3'd2, "s_neg"});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 3'd0, "illegal"});
    foreach (vecs[i]) apply(vecs[i]);

    // Sweep every immediate-bearing opcode with random upper bits
    ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    for (int r = 0; r < 8; r++) begin
      foreach (ops[k]) begin
        @(posedge clk); #1;
        instr = {$urandom(), ops[k]} & 32'hFFFFFFFF;
        instr[6:0] = ops[k];
      end
    end

    // Registered path: capture, then reset mid-stream with instr held
    @(posedge clk); #1;
    instr = 32'hFFF10093;
    @(posedge clk); #1;
    check("reg_capture",  imm_q, 32'hFFFFFFFF);
    check("reg_type_cap", {29'd0, imm_type_q}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reg_midrst",   imm_q, 32'd0);
    check("reg_midrst_t", {29'd0, imm_type_q}, 32'd0);
    check("comb_in_rst",  imm_out, 32'hFFFFFFFF);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reg_recapture", imm_q, 32'hFFFFFFFF);

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
Name: imm_gen

Overview:
- RV32I immediate generator in the decode stage of the single-issue RISC-V core.
- Takes the raw 32-bit instruction and selects the immediate format from opcode[6:0].
- Outputs the sign-extended (or, for U-type, left-shifted) 32-bit immediate combinationally, plus a format code and a valid flag.
- Also provides a one-cycle registered copy for pipelined datapaths.

Parameters:
- XLEN, 32, output immediate width; only 32 is supported.
- REG_OUT, 1, when 1 the registered outputs imm_q/imm_type_q are implemented; when 0 they are tied to 0.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  32  raw instruction word.
- imm_out  output  32  combinational immediate.
- imm_type  output  3  format code: 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT.
- imm_valid  output  1  high when opcode carries an immediate.
- imm_q  output  32  imm_out registered on clk.
- imm_type_q  output  3  imm_type registered on clk.

Behaviour:
- imm_out, imm_type and imm_valid are purely combinational from instr, with zero latency. They do not depend on clk or rst.
- Opcode decode:
  - I: 0000011 (load), 0010011 (OP-IMM), 1100111 (JALR), 0001111 (FENCE), 1110011 (SYSTEM). imm = sext(instr[31:20]).
  - SHAMT: opcode 0010011 with funct3 = 001 or 101. imm = zext(instr[24:20]), so bit 30 (the SRAI marker) is excluded.
  - S: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: 0110111 (LUI), 0010111 (AUIPC). imm = {instr[31:12], 12'b0}.
  - J: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode (R-type 0110011, all-zero, illegal): imm_out = 0, imm_type = NONE, imm_valid = 0.
- Sign extension always uses instr[31].
- B and J immediates always have bit 0 = 0.
- U immediates always have bits [11:0] = 0.
- imm_valid = 1 for every type except NONE.
- Registered path: on each rising clk edge, imm_q <= imm_out and imm_type_q <= imm_type.
- When rst = 1 at a rising edge, imm_q = 0 and imm_type_q = 0. Reset takes priority over the capture.
- Registered outputs are 0 from the first reset edge onward; they are X before any reset.
- Reset asserted mid-stream clears the registers on that edge only. The combinational outputs are unaffected by reset.

Decomposition:
- Shared package rv_pkg holds:
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
  - imm_type_e enum (NONE, I, S, B, U, J, SHAMT).
- No sub-module is needed. The decode and the output register live in one block, with a generate gate on REG_OUT.

Test Plan:
- I-type: instr=32'hFFF10093 -> imm_out=32'hFFFFFFFF, imm_type=I, imm_valid=1. Also instr=32'h7FF00013 -> imm_out=32'h000007FF.
- S-type: instr=32'h00112423 -> imm_out=32'h00000008, type=S.
- B-type: instr=32'h00208063 -> imm_out=0, type=B. Also instr=32'hFE000EE3 -> imm_out=32'hFFFFFFFC.
- U-type: instr=32'h000120B7 -> imm_out=32'h00012000, type=U. J-type: instr=32'h004000EF -> imm_out=32'h00000004, type=J.
- Default and shift:
  - instr=0 -> imm_out=0, type=NONE, valid=0.
  - instr=32'h40305093 (SRAI by 3) -> imm_out=3, type=SHAMT.
  - R-type 32'h002081B3 -> imm_out=0, valid=0.
- Registered path:
  - Hold rst=1 for 2 clocks -> imm_q=0, imm_type_q=0.
  - Release rst, drive 32'hFFF10093 -> one edge later imm_q=32'hFFFFFFFF.
  - Assert rst with instr unchanged -> next edge imm_q=0 while imm_out stays 32'hFFFFFFFF.
